bif_dpath_lbd_addr_queue: RTL

BIF_DPATH_LBD_ADDR_QUEUE -- requirements
Module: bif_dpath_lbd_addr_queue

---
 rtl/bif_dpath_lbd_addr_queue.sv | 86 ++++++++
 1 files changed

// File: rtl/bif_dpath_lbd_addr_queue.sv
// LBD address capture queue: edge-triggered captures of {PPN,CA} into a small FIFO,
// head presented on LBD under an active-low output enable, with a sticky overflow flag.
module bif_dpath_lbd_addr_queue #(
    parameter int unsigned PPN_W = 14,
    parameter int unsigned CA_W  = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                             sysclk,
    input  logic                             sys_rst,
    input  logic                             ECREQ,
    input  logic [PPN_W-1:0]                 PPN,
    input  logic [CA_W-1:0]                  CA,
    input  logic                             EADR_n,
    input  logic                             ADR_ACK,
    input  logic                             CLR_OVF,
    output logic [PPN_W+CA_W-1:0]            LBD,
    output logic                             EMPTY,
    output logic                             FULL,
    output logic [$clog2(DEPTH+1)-1:0]       COUNT,
    output logic                             OVF
);

    localparam int unsigned LBD_W = PPN_W + CA_W;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [LBD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_ecreq_q;

    logic w_push;
    logic w_pop;
    logic w_wr;
    logic w_ovf_set;
    logic w_empty;
    logic w_full;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_push    = ECREQ & ~r_ecreq_q;
    assign w_pop     = ADR_ACK & ~w_empty;
    // When full, a simultaneous pop frees the slot the push lands in.
    assign w_wr      = w_push & (~w_full | w_pop);
    assign w_ovf_set = w_push & w_full & ~w_pop;

    always_ff @(posedge sysclk) begin
        if (sys_rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_ecreq_q <= 1'b1;
        end else begin
            r_ecreq_q <= ECREQ;
            if (w_wr) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            r_ovf <= w_ovf_set | (r_ovf & ~CLR_OVF);
        end
    end

    // Entry storage is never reset; validity is tracked by the pointers and count.
    always_ff @(posedge sysclk) begin
        if (!sys_rst && w_wr) begin
            r_mem[r_tail] <= {PPN, CA};
        end
    end

    assign LBD   = (!EADR_n && !w_empty) ? r_mem[r_head] : '0;
    assign EMPTY = w_empty;
    assign FULL  = w_full;
    assign COUNT = r_count;
    assign OVF   = r_ovf;

endmodule
